// File: rtl/crop_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one crop filter from two pixel sources.
// Optional stall watchdog is enabled with `define FRAME_TIMEOUT_EN.
module crop_frame_arbiter #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS         = 40,
  parameter int IN_COLS         = 40,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] s0_pixel,
  input  logic                       s0_valid,
  output logic                       s0_ready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s1_pixel,
  input  logic                       s1_valid,
  output logic                       s1_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] m_pixel,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_src,
  output logic                       frame_start,
  output logic                       frame_abort
);

  localparam int FRAME_PIX = IN_ROWS * IN_COLS;
  localparam int CNT_W     = $clog2(FRAME_PIX) + 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pixCnt_q, pixCnt_d;
  logic               lastGrant_q, lastGrant_d;
  logic               mSrc_q, mSrc_d;
  logic               beat;

`ifdef FRAME_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]    wdCnt_q, wdCnt_d;
  logic               frameAbort_q, frameAbort_d;
`else
  logic [31:0]        unusedTimeout;
  assign unusedTimeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    pixCnt_d    = pixCnt_q;
    lastGrant_d = lastGrant_q;
    mSrc_d      = mSrc_q;
    s0_ready    = 1'b0;
    s1_ready    = 1'b0;
    m_valid     = 1'b0;
    m_pixel     = '0;
    unique case (state_q)
      IDLE: begin
        // Source 0 wins when alone, or on a tie when source 1 had the last frame.
        if (s0_valid && (!s1_valid || lastGrant_q)) begin
          state_d     = GRANT0;
          mSrc_d      = 1'b0;
          lastGrant_d = 1'b0;
        end else if (s1_valid) begin
          state_d     = GRANT1;
          mSrc_d      = 1'b1;
          lastGrant_d = 1'b1;
        end
      end
      GRANT0: begin
        m_pixel  = s0_pixel;
        m_valid  = s0_valid;
        s0_ready = m_ready;
      end
      GRANT1: begin
        m_pixel  = s1_pixel;
        m_valid  = s1_valid;
        s1_ready = m_ready;
      end
      default: state_d = IDLE;
    endcase

    frame_start = m_valid && (pixCnt_q == '0);
    beat        = m_valid && m_ready;
    if (beat) begin
      if (pixCnt_q == CNT_W'(FRAME_PIX - 1)) begin
        pixCnt_d = '0;
        state_d  = IDLE;
      end else begin
        pixCnt_d = pixCnt_q + CNT_W'(1);
      end
    end

`ifdef FRAME_TIMEOUT_EN
    // Only a granted source withholding data while the filter is ready counts as a stall.
    wdCnt_d      = '0;
    frameAbort_d = 1'b0;
    if (state_q != IDLE && !m_valid && m_ready) begin
      if (wdCnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        frameAbort_d = 1'b1;
        pixCnt_d     = '0;
        state_d      = IDLE;
      end else begin
        wdCnt_d = wdCnt_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pixCnt_q    <= '0;
      lastGrant_q <= 1'b1;
      mSrc_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixCnt_q    <= pixCnt_d;
      lastGrant_q <= lastGrant_d;
      mSrc_q      <= mSrc_d;
    end
  end

  assign m_src = mSrc_q;

`ifdef FRAME_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wdCnt_q      <= '0;
      frameAbort_q <= 1'b0;
    end else begin
      wdCnt_q      <= wdCnt_d;
      frameAbort_q <= frameAbort_d;
    end
  end

  assign frame_abort = frameAbort_q;
`else
  assign frame_abort = 1'b0;
`endif

endmodule

// File: tb/tb_crop_frame_arbiter.sv
// Directed bench for crop_frame_arbiter with 4x4 frames; covers the watchdog when
// FRAME_TIMEOUT_EN is defined.
module tb_crop_frame_arbiter;

  localparam int PW = 12;
  localparam int FRAME_PIX = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] s0_pixel, s1_pixel, m_pixel;
  logic          s0_valid, s1_valid, s0_ready, s1_ready;
  logic          m_valid, m_ready, m_src, frame_start, frame_abort;

  crop_frame_arbiter #(
    .PIXEL_BIT_WIDTH(PW),
    .IN_ROWS(4),
    .IN_COLS(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s0_pixel(s0_pixel),
    .s0_valid(s0_valid),
    .s0_ready(s0_ready),
    .s1_pixel(s1_pixel),
    .s1_valid(s1_valid),
    .s1_ready(s1_ready),
    .m_pixel(m_pixel),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_src(m_src),
    .frame_start(frame_start),
    .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  // Source models: whether each source requests, and the pixel it currently holds.
  logic          want0, want1;
  logic [PW-1:0] pix0, pix1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic mr);
    s0_valid = want0;
    s0_pixel = pix0;
    s1_valid = want1;
    s1_pixel = pix1;
    m_ready  = mr;
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_m_src"}, m_src, 0);
    checkOutput({tag, "_abort"}, frame_abort, 0);
    checkOutput({tag, "_m_valid"}, m_valid, 0);
    checkOutput({tag, "_m_pixel"}, m_pixel, 0);
    checkOutput({tag, "_readies"}, {s0_ready, s1_ready}, 0);
    checkOutput({tag, "_fstart"}, frame_start, 0);
  endtask

  task automatic applyReset();
    want0 = 1'b0;
    want1 = 1'b0;
    pix0  = 12'h000;
    pix1  = 12'h100;
    reset = 1'b1;
    applyStimulus(1'b1);
    repeat (2) @(negedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b0;
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b1);
    checkOutput({tag, "_m_valid"}, m_valid, 0);
    checkOutput({tag, "_readies"}, {s0_ready, s1_ready}, 0);
    checkOutput({tag, "_fstart"}, frame_start, 0);
    @(negedge clk);
  endtask

  // Expects the granted source to stream nBeats pixels; m_ready drops for
  // stallLen cycles when beat stallAt is presented.
  task automatic runFrame(input logic src, input int nBeats, input int stallAt, input int stallLen);
    int beats = 0;
    int stalled = 0;
    logic mr;
    while (beats < nBeats) begin
      mr = !(beats == stallAt && stalled < stallLen);
      applyStimulus(mr);
      checkOutput("m_src", m_src, src);
      checkOutput("m_valid", m_valid, 1);
      checkOutput("m_pixel", m_pixel, src ? pix1 : pix0);
      checkOutput("frame_start", frame_start, beats == 0);
      checkOutput("own_ready", src ? s1_ready : s0_ready, mr);
      checkOutput("other_ready", src ? s0_ready : s1_ready, 0);
      checkOutput("frame_abort", frame_abort, 0);
      if (mr) begin
        beats++;
        if (src) pix1++;
        else pix0++;
      end else begin
        stalled++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    want0 = 1'b0;
    want1 = 1'b0;
    pix0  = '0;
    pix1  = '0;
    @(negedge clk);

    $display("[TB] single source, back-to-back frames, mid-frame stall");
    applyReset();
    want0 = 1'b1;
    idleCycle("first_idle");
    runFrame(1'b0, FRAME_PIX, -1, 0);
    idleCycle("gap0");
    runFrame(1'b0, FRAME_PIX, 7, 5);
    idleCycle("gap1");

    $display("[TB] both sources, round-robin");
    applyReset();
    want0 = 1'b1;
    want1 = 1'b1;
    idleCycle("rr_idle");
    runFrame(1'b0, FRAME_PIX, -1, 0);
    idleCycle("rr_gap0");
    runFrame(1'b1, FRAME_PIX, -1, 0);
    idleCycle("rr_gap1");
    runFrame(1'b0, FRAME_PIX, -1, 0);
    idleCycle("rr_gap2");

    $display("[TB] reset during source 1 frame");
    runFrame(1'b1, 9, -1, 0);
    reset = 1'b1;
    applyStimulus(1'b1);
    @(negedge clk);
    #1;
    checkResetState("midreset");
    reset = 1'b0;
    want1 = 1'b0;
    pix0  = 12'h000;
    idleCycle("post_reset_idle");
    runFrame(1'b0, FRAME_PIX, -1, 0);
    want0 = 1'b0;
    idleCycle("post_reset_gap");
    idleCycle("quiet");

`ifdef FRAME_TIMEOUT_EN
    $display("[TB] watchdog abort");
    want0 = 1'b1;
    idleCycle("wd_idle");
    runFrame(1'b0, 4, -1, 0);
    want0 = 1'b0;
    want1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1);
      checkOutput("wd_stall_valid", m_valid, 0);
      checkOutput("wd_stall_abort", frame_abort, 0);
      checkOutput("wd_stall_s1rdy", s1_ready, 0);
      @(negedge clk);
    end
    want0 = 1'b1;
    applyStimulus(1'b1);
    checkOutput("wd_abort_pulse", frame_abort, 1);
    checkOutput("wd_abort_idle", m_valid, 0);
    @(negedge clk);
    runFrame(1'b1, FRAME_PIX, -1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
